// File: rtl/modexp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : modexp_ctrl
// Description : Left-to-right square-and-multiply sequencer computing
//               result = m^e mod n by driving one external MonPro
//               (Montgomery product) core through a start/done handshake.
//               Optional build macro MODEXP_LZ_SKIP_EN: skip leading zero
//               exponent bits (one bit per cycle, no MonPro operation).
// Revision    : 1.0 - initial release
// ============================================================================
module modexp_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_W      = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] m_in,
    input  logic [DATA_WIDTH-1:0] e_in,
    input  logic [DATA_WIDTH-1:0] n_in,
    input  logic [DATA_WIDTH-1:0] r2_in,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  mp_start,
    output logic [DATA_WIDTH-1:0] mp_a,
    output logic [DATA_WIDTH-1:0] mp_b,
    output logic [DATA_WIDTH-1:0] mp_n,
    input  logic                  mp_done,
    input  logic [DATA_WIDTH-1:0] mp_result
);

    localparam logic [DATA_WIDTH-1:0] C_ONE      = DATA_WIDTH'(1);
    localparam logic [CNT_W-1:0]      C_LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]      C_CNT_ZERO = '0;
    localparam logic                  C_PH_ISSUE = 1'b0;
    localparam logic                  C_PH_WAIT  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_M2MONT   = 3'd1,
        S_X2MONT   = 3'd2,
        S_SQR      = 3'd3,
        S_MUL      = 3'd4,
        S_FROMMONT = 3'd5,
`ifdef MODEXP_LZ_SKIP_EN
        S_FIN      = 3'd6,
        S_SKIP     = 3'd7
`else
        S_FIN      = 3'd6
`endif
    } state_t;

    state_t                state_q,  state_d;
    logic                  phase_q,  phase_d;
    logic [DATA_WIDTH-1:0] e_q,      e_d;      // exponent, current bit at MSB
    logic [DATA_WIDTH-1:0] n_q,      n_d;
    logic [DATA_WIDTH-1:0] r2_q,     r2_d;
    logic [DATA_WIDTH-1:0] mbar_q,   mbar_d;
    logic [DATA_WIDTH-1:0] xbar_q,   xbar_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;    // index of the bit at e_q MSB
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [DATA_WIDTH-1:0] mp_a_q,   mp_a_d;
    logic [DATA_WIDTH-1:0] mp_b_q,   mp_b_d;

    logic w_op_state;
    logic w_op_done;

    // States that own a MonPro operation and therefore an ISSUE/WAIT phase.
    assign w_op_state = (state_q == S_M2MONT) || (state_q == S_X2MONT) ||
                        (state_q == S_SQR)    || (state_q == S_MUL)    ||
                        (state_q == S_FROMMONT);
    assign w_op_done  = w_op_state && (phase_q == C_PH_WAIT) && mp_done;

    assign busy     = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done     = (state_q == S_FIN);
    assign mp_start = w_op_state && (phase_q == C_PH_ISSUE);
    assign mp_a     = mp_a_q;
    assign mp_b     = mp_b_q;
    assign mp_n     = n_q;
    assign result   = result_q;

    // State register and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            phase_q  <= C_PH_ISSUE;
            e_q      <= '0;
            n_q      <= '0;
            r2_q     <= '0;
            mbar_q   <= '0;
            xbar_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            mp_a_q   <= '0;
            mp_b_q   <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            e_q      <= e_d;
            n_q      <= n_d;
            r2_q     <= r2_d;
            mbar_q   <= mbar_d;
            xbar_q   <= xbar_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            mp_a_q   <= mp_a_d;
            mp_b_q   <= mp_b_d;
        end
    end

    // Next-state logic; operands for the next operation are loaded on the
    // transition so they are already stable during its ISSUE cycle.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        e_d      = e_q;
        n_d      = n_q;
        r2_d     = r2_q;
        mbar_d   = mbar_q;
        xbar_d   = xbar_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        mp_a_d   = mp_a_q;
        mp_b_d   = mp_b_q;

        if (w_op_state && (phase_q == C_PH_ISSUE)) begin
            phase_d = C_PH_WAIT;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_M2MONT;
                    phase_d = C_PH_ISSUE;
                    e_d     = e_in;
                    n_d     = n_in;
                    r2_d    = r2_in;
                    mp_a_d  = m_in;
                    mp_b_d  = r2_in;
                end
            end
            S_M2MONT: begin
                if (w_op_done) begin
                    mbar_d  = mp_result;
                    state_d = S_X2MONT;
                    phase_d = C_PH_ISSUE;
                    mp_a_d  = C_ONE;
                    mp_b_d  = r2_q;
                end
            end
            S_X2MONT: begin
                if (w_op_done) begin
                    xbar_d  = mp_result;
                    cnt_d   = C_LAST_BIT;
                    phase_d = C_PH_ISSUE;
`ifdef MODEXP_LZ_SKIP_EN
                    state_d = S_SKIP;
`else
                    state_d = S_SQR;
                    mp_a_d  = mp_result;
                    mp_b_d  = mp_result;
`endif
                end
            end
`ifdef MODEXP_LZ_SKIP_EN
            S_SKIP: begin
                if (e_q[DATA_WIDTH-1]) begin
                    state_d = S_SQR;
                    mp_a_d  = xbar_q;
                    mp_b_d  = xbar_q;
                end else if (cnt_q == C_CNT_ZERO) begin
                    state_d = S_FROMMONT;
                    mp_a_d  = xbar_q;
                    mp_b_d  = C_ONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    e_d   = e_q << 1;
                end
            end
`endif
            S_SQR: begin
                if (w_op_done) begin
                    xbar_d  = mp_result;
                    phase_d = C_PH_ISSUE;
                    if (e_q[DATA_WIDTH-1]) begin
                        state_d = S_MUL;
                        mp_a_d  = mp_result;
                        mp_b_d  = mbar_q;
                    end else if (cnt_q == C_CNT_ZERO) begin
                        state_d = S_FROMMONT;
                        mp_a_d  = mp_result;
                        mp_b_d  = C_ONE;
                    end else begin
                        state_d = S_SQR;
                        cnt_d   = cnt_q - 1'b1;
                        e_d     = e_q << 1;
                        mp_a_d  = mp_result;
                        mp_b_d  = mp_result;
                    end
                end
            end
            S_MUL: begin
                if (w_op_done) begin
                    xbar_d  = mp_result;
                    phase_d = C_PH_ISSUE;
                    if (cnt_q == C_CNT_ZERO) begin
                        state_d = S_FROMMONT;
                        mp_a_d  = mp_result;
                        mp_b_d  = C_ONE;
                    end else begin
                        state_d = S_SQR;
                        cnt_d   = cnt_q - 1'b1;
                        e_d     = e_q << 1;
                        mp_a_d  = mp_result;
                        mp_b_d  = mp_result;
                    end
                end
            end
            S_FROMMONT: begin
                if (w_op_done) begin
                    result_d = mp_result;
                    state_d  = S_FIN;
                    phase_d  = C_PH_ISSUE;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                phase_d = C_PH_ISSUE;
            end
        endcase
    end

endmodule
`default_nettype wire
